// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared constants and pointer helper for the parametrised FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Read-mode selectors for the FWFT parameter
  localparam bit FIFO_MODE_REG  = 1'b0;
  localparam bit FIFO_MODE_FWFT = 1'b1;

  // Pointer increment with explicit wrap at depth-1, so any depth works
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram_sdp.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ram_sdp
// Brief    : Simple dual-port storage, synchronous write, asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ram_sdp #(
  parameter  int BIT_D = 32,
  parameter  int DEPTH = 6,
  localparam int ADR   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADR-1:0]   waddr,
  input  logic [BIT_D-1:0] wdata,
  input  logic [ADR-1:0]   raddr,
  output logic [BIT_D-1:0] rdata
);

  // Contents are deliberately not reset
  logic [BIT_D-1:0] mem [DEPTH];

  // Write port: store data on the accepted push
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_param
// Brief    : Single-clock FIFO, any depth, programmable almost flags,
//            registered or first-word-fall-through read, sticky errors.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter  int BIT_D  = 32,
  parameter  int DEPTH  = 6,
  parameter  int AF_LVL = 5,
  parameter  int AE_LVL = 1,
  parameter  bit FWFT   = FIFO_MODE_REG,
  localparam int ADR    = $clog2(DEPTH),
  localparam int CNT    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             wr_i,
  input  logic [BIT_D-1:0] data_i,
  input  logic             rd_i,
  input  logic             clr_err_i,
  output logic [BIT_D-1:0] data_o,
  output logic             rd_valid_o,
  output logic [CNT-1:0]   fifo_cnt_o,
  output logic             wr_full_o,
  output logic             rd_empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam logic [CNT-1:0] DEPTH_C = CNT'(DEPTH);
  localparam logic [CNT-1:0] AF_C    = CNT'(AF_LVL);
  localparam logic [CNT-1:0] AE_C    = CNT'(AE_LVL);

  logic [ADR-1:0]   wr_ptr;
  logic [ADR-1:0]   rd_ptr;
  logic [BIT_D-1:0] rd_data;
  logic             push_ok;
  logic             pop_ok;

  // Flags depend on the occupancy count alone
  assign wr_full_o      = (fifo_cnt_o == DEPTH_C);
  assign rd_empty_o     = (fifo_cnt_o == '0);
  assign almost_full_o  = (fifo_cnt_o >= AF_C);
  assign almost_empty_o = (fifo_cnt_o <= AE_C);

  // A full FIFO still takes a push when a pop frees a slot in the same cycle
  assign pop_ok  = rd_i && !rd_empty_o;
  assign push_ok = wr_i && (!wr_full_o || pop_ok);

  fifo_ram_sdp #(
    .BIT_D (BIT_D),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk_i),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (data_i),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Pointers and occupancy count
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt_o <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= ADR'(ptr_inc(32'(wr_ptr), 32'(DEPTH)));
      end
      if (pop_ok) begin
        rd_ptr <= ADR'(ptr_inc(32'(rd_ptr), 32'(DEPTH)));
      end
      case ({push_ok, pop_ok})
        2'b10:   fifo_cnt_o <= fifo_cnt_o + 1'b1;
        2'b01:   fifo_cnt_o <= fifo_cnt_o - 1'b1;
        default: fifo_cnt_o <= fifo_cnt_o;
      endcase
    end
  end

  // Sticky error flags; a fresh error beats a simultaneous clear
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_i && !push_ok) begin
        overflow_o <= 1'b1;
      end else if (clr_err_i) begin
        overflow_o <= 1'b0;
      end
      if (rd_i && !pop_ok) begin
        underflow_o <= 1'b1;
      end else if (clr_err_i) begin
        underflow_o <= 1'b0;
      end
    end
  end

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head of queue is always visible; valid whenever something is stored
      assign data_o     = rd_data;
      assign rd_valid_o = !rd_empty_o;
    end else begin : g_reg
      // Registered read: capture head on pop, valid pulses for one cycle
      always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
          data_o     <= '0;
          rd_valid_o <= 1'b0;
        end else begin
          rd_valid_o <= pop_ok;
          if (pop_ok) begin
            data_o <= rd_data;
          end
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire
